// File: rtl/npc_pkg.sv
// Shared NPC core definitions: datapath widths, reset vector and fetch FSM encoding.
package npc_pkg;

   localparam int unsigned NPC_XLEN     = 32;
   localparam int unsigned NPC_ILEN     = 32;
   localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
   // Instruction word presented to decode when the fetch faulted
   localparam logic [31:0] FAULT_INST   = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_WAIT = 2'd2,
      FS_HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem read, single-entry instruction buffer,
// redirect handling with wrong-path response discard.
module ifu_fetch
   import npc_pkg::*;
#(
   parameter int unsigned     XLEN     = NPC_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(NPC_RESET_PC)
) (
   input  logic            clk,
   input  logic            rstn,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            imem_rsp_err,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_inst,
   output logic            id_fault
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] addr_q;
   logic            drop_q, drop_d;
   logic [31:0]     inst_q;
   logic            fault_q;
   logic            req_valid_q;
   logic            id_valid_q;
   logic            capture;
   logic [XLEN-1:0] redirect_aligned;

   assign redirect_aligned = redirect_pc & ~XLEN'(3);

   // Next-state, next-pc and wrong-path drop tracking
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      capture = 1'b0;
      case (state_q)
         FS_IDLE: state_d = FS_REQ;
         FS_REQ: begin
            if (imem_req_ready) state_d = FS_WAIT;
         end
         FS_WAIT: begin
            if (imem_rsp_valid) begin
               if (drop_q || redirect_valid) begin
                  drop_d  = 1'b0;
                  state_d = FS_REQ;
               end else begin
                  capture = 1'b1;
                  state_d = FS_HOLD;
               end
            end
         end
         FS_HOLD: begin
            if (redirect_valid) begin
               state_d = FS_REQ;
            end else if (id_ready) begin
               pc_d    = pc_q + XLEN'(4);
               state_d = FS_REQ;
            end
         end
         default: state_d = FS_IDLE;
      endcase

      // A request already on the bus (or in flight) belongs to the old path
      if (redirect_valid) begin
         pc_d = redirect_aligned;
         if ((state_q == FS_REQ) || ((state_q == FS_WAIT) && !imem_rsp_valid))
            drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= FS_IDLE;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         drop_q      <= 1'b0;
         inst_q      <= 32'h0;
         fault_q     <= 1'b0;
         req_valid_q <= 1'b0;
         id_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_q      <= drop_d;
         req_valid_q <= (state_d == FS_REQ);
         id_valid_q  <= (state_d == FS_HOLD);
         // Address is frozen while a request waits for ready
         if (!((state_q == FS_REQ) && (state_d == FS_REQ)))
            addr_q <= pc_d;
         if (capture) begin
            inst_q  <= imem_rsp_err ? FAULT_INST : imem_rsp_data;
            fault_q <= imem_rsp_err;
         end
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = addr_q;
   assign id_valid       = id_valid_q;
   assign id_pc          = pc_q;
   assign id_inst        = inst_q;
   assign id_fault       = fault_q;

   rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rstn)
      imem_rsp_valid |-> (state_q == FS_WAIT));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rstn;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_fault;

   int n_cmp = 0;
   int n_err = 0;

   ifu_fetch dut (
      .clk            (clk),
      .rstn           (rstn),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_inst        (id_inst),
      .id_fault       (id_fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full REQ -> WAIT -> HOLD -> accept sequence with zero-wait memory
   task automatic fetch_one(input logic [31:0] exp_pc, input logic [31:0] data, input logic err);
      logic [31:0] exp_inst;
      exp_inst = err ? 32'h0 : data;
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc || id_valid !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_req: valid=%b addr=%h id_valid=%b, required 1 %h 0",
                  imem_req_valid, imem_req_addr, id_valid, exp_pc);
      end
      tick();
      n_cmp++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_wait: req_valid=%b id_valid=%b, required 0 0", imem_req_valid, id_valid);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      imem_rsp_err   = err;
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== exp_pc || id_inst !== exp_inst || id_fault !== err) begin
         n_err++;
         $display("FAIL fetch_hold: valid=%b pc=%h inst=%h fault=%b, required 1 %h %h %b",
                  id_valid, id_pc, id_inst, id_fault, exp_pc, exp_inst, err);
      end
      tick();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_err = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
      tick(); tick();
      n_cmp++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_inst !== 32'h0 || id_fault !== 1'b0
          || imem_req_addr !== 32'h8000_0000 || id_pc !== 32'h8000_0000) begin
         n_err++;
         $display("FAIL reset_state: rv=%b iv=%b inst=%h flt=%b addr=%h pc=%h, required 0 0 0 0 80000000 80000000",
                  imem_req_valid, id_valid, id_inst, id_fault, imem_req_addr, id_pc);
      end
      rstn = 1'b1;
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: req_valid=%b, required 0", imem_req_valid);
      end
      tick();
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
         n_err++;
         $display("FAIL reset_first_req: valid=%b addr=%h, required 1 80000000", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_stall();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: valid=%b addr=%h id_valid=%b, required 1 80000000 0",
                     i, imem_req_valid, imem_req_addr, id_valid);
         end
         tick();
      end
   endtask

   task automatic test_stream();
      fetch_one(32'h8000_0000, 32'h0000_0413, 1'b0);
      fetch_one(32'h8000_0004, 32'h0000_0413, 1'b0);
      fetch_one(32'h8000_0008, 32'h0000_0413, 1'b0);
   endtask

   task automatic test_fault();
      fetch_one(32'h8000_000C, 32'h0010_0093, 1'b0);
      fetch_one(32'h8000_0010, 32'hFFFF_FFFF, 1'b1);
      fetch_one(32'h8000_0014, 32'h0020_0113, 1'b0);
   endtask

   task automatic test_redirect_wait();
      imem_req_ready = 1'b1;
      n_cmp++;
      if (imem_req_addr !== 32'h8000_0018) begin
         n_err++;
         $display("FAIL redir_wait_pre: addr=%h, required 80000018", imem_req_addr);
      end
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0100;
      tick();
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      imem_rsp_valid = 1'b0;
      n_cmp++;
      if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
         n_err++;
         $display("FAIL redir_wait_drop: id_valid=%b req_valid=%b addr=%h, required 0 1 80000100",
                  id_valid, imem_req_valid, imem_req_addr);
      end
      fetch_one(32'h8000_0100, 32'h0030_0193, 1'b0);
   endtask

   task automatic test_hold_redirect();
      int transfers;
      transfers = 0;
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h00C5_8533;
      tick();
      imem_rsp_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (id_valid !== 1'b1 || id_pc !== 32'h8000_0104 || id_inst !== 32'h00C5_8533) begin
            n_err++;
            $display("FAIL hold_stall[%0d]: valid=%b pc=%h inst=%h, required 1 80000104 00c58533",
                     i, id_valid, id_pc, id_inst);
         end
         tick();
      end
      id_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0203;
      if (id_valid === 1'b1) transfers++;
      tick();
      redirect_valid = 1'b0;
      if (id_valid === 1'b1) transfers++;
      n_cmp++;
      if (transfers !== 1) begin
         n_err++;
         $display("FAIL hold_transfer_count: %0d, required 1", transfers);
      end
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200 || id_pc !== 32'h8000_0200) begin
         n_err++;
         $display("FAIL hold_redirect_addr: valid=%b addr=%h pc=%h, required 1 80000200 80000200",
                  imem_req_valid, imem_req_addr, id_pc);
      end
   endtask

   task automatic test_reset_midflight();
      imem_req_ready = 1'b1;
      tick();
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_wait: req_valid=%b, required 0", imem_req_valid);
      end
      rstn = 1'b0;
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_inst !== 32'h0 || id_fault !== 1'b0
          || imem_req_addr !== 32'h8000_0000 || id_pc !== 32'h8000_0000) begin
         n_err++;
         $display("FAIL midrst_values: rv=%b iv=%b inst=%h flt=%b addr=%h pc=%h, required 0 0 0 0 80000000 80000000",
                  imem_req_valid, id_valid, id_inst, id_fault, imem_req_addr, id_pc);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1234_5678;
      tick();
      imem_rsp_valid = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      n_cmp++;
      if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || id_inst !== 32'h0) begin
         n_err++;
         $display("FAIL midrst_restart: iv=%b rv=%b addr=%h inst=%h, required 0 1 80000000 00000000",
                  id_valid, imem_req_valid, imem_req_addr, id_inst);
      end
      fetch_one(32'h8000_0000, 32'h0000_0413, 1'b0);
   endtask

   initial begin
      test_reset();
      test_stall();
      test_stream();
      test_fault();
      test_redirect_wait();
      test_hold_redirect();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
